sdram_wr_pattern_gen: RTL and testbench

Synthesizable, parametrised frame-pattern source feeding the SDRAM controller's write FIFO (`wfifo_en`/`wfifo_data`). It generates raster frames of `V_ACTIVE` rows × `H_ACTIVE` words with a programmable inter-row gap, and starts only after SDRAM initialisation (`ini_end`). It adds four selectable data patterns, FIFO back-pressure, frame-done signalling, and abort on re-init. It sits between the top-level start control and `sdram_main_ctrl`, replacing bench-forced write stimulus in on-board bring-up.

---
 rtl/sdram_wr_pattern_gen_if.sv | 28 ++
 rtl/sdram_wr_pattern_gen.sv | 188 ++++++++++++++++++
 tb/tb_sdram_wr_pattern_gen.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_wr_pattern_gen_if.sv
// Write-FIFO side bundle of the frame pattern generator.
// master = generator, slave = FIFO / start control side.
interface sdram_wr_pattern_gen_if #(
  parameter int unsigned DW    = 8,
  parameter int unsigned CNT_W = 16
);
  logic             ini_end;
  logic             start;
  logic [1:0]       mode;
  logic             wfifo_full;
  logic             wfifo_en;
  logic [DW-1:0]    wfifo_data;
  logic             busy;
  logic             frame_done;
  logic [CNT_W-1:0] cur_row;

  modport master (
    input  ini_end, start, mode, wfifo_full,
    output wfifo_en, wfifo_data, busy,
    output frame_done, cur_row
  );

  modport slave (
    output ini_end, start, mode, wfifo_full,
    input  wfifo_en, wfifo_data, busy,
    input  frame_done, cur_row
  );
endinterface

// File: rtl/sdram_wr_pattern_gen.sv
// Raster test-pattern source for the SDRAM write FIFO.
// Frames start after ini_end and abort if init drops.
module sdram_wr_pattern_gen #(
  parameter int unsigned DW        = 8,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned H_GAP     = 1000,
  parameter int unsigned START_DLY = 5,
  parameter int unsigned CNT_W     = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  sdram_wr_pattern_gen_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, WAIT_INI, DLY, ACTIVE, GAP, DONE
  } state_t;

  localparam logic [CNT_W-1:0] COL_LAST =
    CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] ROW_LAST =
    CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(H_GAP - 1);
  localparam logic [CNT_W-1:0] DLY_LAST =
    CNT_W'(START_DLY - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [15:0] SEED = 16'hACE1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] dly_q, dly_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [1:0]       mode_q, mode_d;

  logic             en_q, en_d;
  logic [DW-1:0]    data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] rout_q, rout_d;

  logic accept;
  logic issue;
  logic abort;
  logic lfsr_fb;

  assign accept = bus.start &&
    (state_q == IDLE || state_q == DONE);
  assign issue = state_q == ACTIVE &&
    bus.ini_end && !bus.wfifo_full;
  assign abort = !bus.ini_end &&
    (state_q == DLY || state_q == ACTIVE ||
     state_q == GAP);
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^
    lfsr_q[12] ^ lfsr_q[10];

  assign bus.wfifo_en   = en_q;
  assign bus.wfifo_data = data_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.cur_row    = rout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      gap_q   <= '0;
      dly_q   <= '0;
      lfsr_q  <= SEED;
      mode_q  <= '0;
      en_q    <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rout_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      gap_q   <= gap_d;
      dly_q   <= dly_d;
      lfsr_q  <= lfsr_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rout_q  <= rout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    gap_d   = gap_q;
    dly_d   = dly_q;
    lfsr_d  = lfsr_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = WAIT_INI;
          mode_d  = bus.mode;
          col_d   = '0;
          row_d   = '0;
          lfsr_d  = SEED;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      WAIT_INI: begin
        if (bus.ini_end) begin
          state_d = DLY;
          dly_d   = '0;
        end
      end
      DLY: begin
        if (abort)
          state_d = IDLE;
        else if (dly_q == DLY_LAST)
          state_d = ACTIVE;
        else
          dly_d = dly_q + ONE;
      end
      ACTIVE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (issue) begin
          lfsr_d = {lfsr_q[14:0], lfsr_fb};
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              state_d = DONE;
            end else if (H_GAP == 0) begin
              row_d = row_q + ONE;
            end else begin
              state_d = GAP;
              gap_d   = '0;
            end
          end else begin
            col_d = col_q + ONE;
          end
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (gap_q == GAP_LAST) begin
          state_d = ACTIVE;
          row_d   = row_q + ONE;
        end else begin
          gap_d = gap_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs are registered; these are their D inputs
  always_comb begin
    en_d   = issue;
    done_d = (state_q == DONE);
    data_d = data_q;
    rout_d = rout_q;
    busy_d = busy_q;
    if (issue) begin
      rout_d = row_q;
      unique case (mode_q)
        2'd0: data_d = DW'(col_q);
        2'd1: data_d = DW'(row_q);
        2'd2: data_d = DW'(row_q ^ col_q);
        2'd3: data_d = DW'(lfsr_q);
      endcase
    end
    if (accept) begin
      busy_d = 1'b1;
      rout_d = '0;
    end else if (abort || state_q == DONE) begin
      busy_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_sdram_wr_pattern_gen.sv
// Scoreboard bench for sdram_wr_pattern_gen: timed and
// untimed frames, stalls, abort, restart and reset.
module tb_sdram_wr_pattern_gen;
  localparam int DW = 8;
  localparam int H  = 3;
  localparam int V  = 4;
  localparam int G  = 2;
  localparam int SD = 5;
  localparam int CW = 16;

  typedef struct {
    logic [DW-1:0] data;
    int            row;
    int            t;
  } word_t;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       ini_end = 1'b0;
  logic       start   = 1'b0;
  logic       full    = 1'b0;
  logic [1:0] mode    = 2'd0;

  int ncmp     = 0;
  int nfail    = 0;
  int edge_n   = 0;
  int na_done  = 0;
  int na_words = 0;
  int b_done_t = -1;
  bit chk_b    = 1'b0;

  word_t qa[$];
  word_t qb[$];
  word_t ea;
  word_t eb;

  sdram_wr_pattern_gen_if #(.DW(DW), .CNT_W(CW)) a_if ();
  sdram_wr_pattern_gen_if #(.DW(DW), .CNT_W(CW)) b_if ();

  assign a_if.ini_end    = ini_end;
  assign a_if.start      = start;
  assign a_if.mode       = mode;
  assign a_if.wfifo_full = full;
  assign b_if.ini_end    = ini_end;
  assign b_if.start      = start;
  assign b_if.mode       = mode;
  assign b_if.wfifo_full = full;

  sdram_wr_pattern_gen #(
    .DW(DW), .H_ACTIVE(H), .V_ACTIVE(V),
    .H_GAP(G), .START_DLY(SD), .CNT_W(CW)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if)
  );

  sdram_wr_pattern_gen #(
    .DW(DW), .H_ACTIVE(H), .V_ACTIVE(V),
    .H_GAP(0), .START_DLY(SD), .CNT_W(CW)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] want);
    ncmp++;
    assert (obs === want) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, want);
    end
  endtask

  // t0 < 0 leaves strobe timing unchecked
  task automatic push_frame(input bit to_b,
                            input logic [1:0] m,
                            input int t0,
                            input int gap);
    logic [15:0] l;
    word_t e;
    l = 16'hACE1;
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < H; c++) begin
        case (m)
          2'd0: e.data = DW'(c);
          2'd1: e.data = DW'(r);
          2'd2: e.data = DW'(r ^ c);
          default: e.data = l[DW-1:0];
        endcase
        l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        e.row = r;
        e.t = (t0 < 0) ? -1 : t0 + r * (H + gap) + c;
        if (to_b) qb.push_back(e);
        else qa.push_back(e);
      end
    end
  endtask

  task automatic wait_edge(input int t);
    while (edge_n < t) @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!a_if.frame_done && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(a_if.frame_done), 1);
  endtask

  always @(negedge clk) begin
    if (a_if.wfifo_en) begin
      na_words++;
      chk("a_pending", 32'(qa.size() > 0), 1);
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        chk("a_data", 32'(a_if.wfifo_data), 32'(ea.data));
        chk("a_row", 32'(a_if.cur_row), ea.row);
        if (ea.t >= 0) chk("a_time", edge_n, ea.t);
      end
    end
    if (a_if.frame_done) na_done++;
  end

  always @(negedge clk) begin
    if (chk_b) begin
      if (b_if.wfifo_en) begin
        chk("b_pending", 32'(qb.size() > 0), 1);
        if (qb.size() > 0) begin
          eb = qb.pop_front();
          chk("b_data", 32'(b_if.wfifo_data), 32'(eb.data));
          chk("b_row", 32'(b_if.cur_row), eb.row);
          chk("b_time", edge_n, eb.t);
        end
      end
      if (b_if.frame_done) b_done_t = edge_n;
    end
  end

  initial begin
    int s, t0, nd, w0, n;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_en", 32'(a_if.wfifo_en), 0);
    chk("rst_data", 32'(a_if.wfifo_data), 0);
    chk("rst_busy", 32'(a_if.busy), 0);
    chk("rst_done", 32'(a_if.frame_done), 0);
    chk("rst_row", 32'(a_if.cur_row), 0);
    rst_n = 1'b1;
    ini_end = 1'b1;
    @(negedge clk);

    // mode 0 timed frame, start mid-row ignored
    s = edge_n + 1;
    t0 = s + 1 + SD + 1;
    push_frame(1'b0, 2'd0, t0, G);
    mode = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t1_busy", 32'(a_if.busy), 1);
    wait_edge(t0 + 6);
    mode = 2'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t1_done_seen");
    chk("t1_done_time", edge_n, t0 + V * H + (V - 1) * G);
    chk("t1_busy_clr", 32'(a_if.busy), 0);
    chk("t1_q_empty", qa.size(), 0);

    // start coincident with frame_done; mode 2 with stall
    s = edge_n + 1;
    t0 = s + 1 + SD + 1;
    w0 = na_words;
    push_frame(1'b0, 2'd2, -1, G);
    mode = 2'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t2_done_pulse", 32'(a_if.frame_done), 0);
    chk("t2_busy", 32'(a_if.busy), 1);
    wait_edge(t0 + H + G);
    full = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t2_stall_en", 32'(a_if.wfifo_en), 0);
    end
    full = 1'b0;
    wait_done("t2_done_seen");
    chk("t2_words", na_words - w0, V * H);
    chk("t2_q_empty", qa.size(), 0);

    // zero-gap instance checked alongside
    repeat (2) @(negedge clk);
    qb.delete();
    b_done_t = -1;
    chk_b = 1'b1;
    s = edge_n + 1;
    t0 = s + 1 + SD + 1;
    push_frame(1'b0, 2'd0, t0, G);
    push_frame(1'b1, 2'd0, t0, 0);
    mode = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t3_done_seen");
    chk("t3_b_done_time", b_done_t, t0 + V * H);
    chk("t3_qb_empty", qb.size(), 0);
    chk("t3_qa_empty", qa.size(), 0);
    chk_b = 1'b0;

    // LFSR pattern under random stalls
    repeat (2) @(negedge clk);
    push_frame(1'b0, 2'd3, -1, G);
    mode = 2'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!a_if.frame_done && n < 2000) begin
      full = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    full = 1'b0;
    chk("t4_done_seen", 32'(a_if.frame_done), 1);
    chk("t4_q_empty", qa.size(), 0);

    // abort on ini_end drop, then restart
    repeat (2) @(negedge clk);
    s = edge_n + 1;
    t0 = s + 1 + SD + 1;
    push_frame(1'b0, 2'd0, -1, G);
    mode = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_edge(t0 + H + G + 1);
    nd = na_done;
    ini_end = 1'b0;
    @(negedge clk);
    chk("t5_abort_en", 32'(a_if.wfifo_en), 0);
    chk("t5_abort_busy", 32'(a_if.busy), 0);
    repeat (30) @(negedge clk);
    chk("t5_no_done", na_done, nd);
    qa.delete();
    mode = 2'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_wait_busy", 32'(a_if.busy), 1);
    chk("t5_wait_en", 32'(a_if.wfifo_en), 0);
    chk("t5_row_clr", 32'(a_if.cur_row), 0);
    s = edge_n;
    ini_end = 1'b1;
    t0 = s + 1 + SD + 1;
    push_frame(1'b0, 2'd1, t0, G);
    wait_done("t5_done_seen");
    chk("t5_done_time", edge_n, t0 + V * H + (V - 1) * G);
    chk("t5_q_empty", qa.size(), 0);

    // asynchronous reset mid-frame
    repeat (2) @(negedge clk);
    s = edge_n + 1;
    t0 = s + 1 + SD + 1;
    push_frame(1'b0, 2'd2, -1, G);
    mode = 2'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_edge(t0 + 2 * (H + G) + 1);
    chk("t6_pre_en", 32'(a_if.wfifo_en), 1);
    chk("t6_pre_row", 32'(a_if.cur_row), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_en", 32'(a_if.wfifo_en), 0);
    chk("t6_rst_data", 32'(a_if.wfifo_data), 0);
    chk("t6_rst_busy", 32'(a_if.busy), 0);
    chk("t6_rst_done", 32'(a_if.frame_done), 0);
    chk("t6_rst_row", 32'(a_if.cur_row), 0);
    qa.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_post_busy", 32'(a_if.busy), 0);
    chk("t6_post_en", 32'(a_if.wfifo_en), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
